// File: rtl/wb_mem_pkg.sv
// Shared types and default parameters for the dual-port Wishbone memory slave.
package wb_mem_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;
  typedef enum logic {GNT_D, GNT_I} grant_e;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADR_W  = 16;
  localparam int unsigned DEF_DEPTH  = 1024;
  localparam int unsigned DEF_WAIT   = 0;

endpackage

// File: rtl/wb_mem_arb.sv
// Two-request round-robin arbiter; one-hot grant, bit 0 = data port, bit 1 = instruction port.
module wb_mem_arb
  import wb_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       d_req_i,
  input  logic       i_req_i,
  input  logic       take_i,
  output logic [1:0] gnt_o
);

  grant_e last_q;

  // On contention the port that did not win last time gets the grant.
  always_comb begin
    gnt_o = '0;
    if (d_req_i && (!i_req_i || last_q == GNT_I)) begin
      gnt_o[0] = 1'b1;
    end else if (i_req_i) begin
      gnt_o[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= GNT_I;
    end else if (take_i && (|gnt_o)) begin
      last_q <= gnt_o[1] ? GNT_I : GNT_D;
    end
  end

endmodule

// File: rtl/wb_dual_mem_slave.sv
// Single-ported word memory shared by a read/write data port and a read-only
// instruction port, with programmable wait states and out-of-range error response.
module wb_dual_mem_slave
  import wb_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADR_W  = DEF_ADR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned WAIT   = DEF_WAIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_cyc_in,
  input  logic                  d_stb_in,
  input  logic                  d_we_in,
  input  logic [ADR_W-1:0]      d_adr_in,
  input  logic [DATA_W-1:0]     d_data_in,
  input  logic [DATA_W/8-1:0]   d_sel_in,
  output logic [DATA_W-1:0]     d_data_out,
  output logic                  d_akn_out,
  output logic                  d_err_out,
  input  logic                  i_cyc_in,
  input  logic                  i_stb_in,
  input  logic [ADR_W-1:0]      i_adr_in,
  output logic [DATA_W-1:0]     i_instr_out,
  output logic                  i_akn_out,
  output logic                  i_err_out
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADR_W:0] DEPTH_L = (ADR_W + 1)'(DEPTH);

  function automatic logic in_range(input logic [ADR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  state_e              state_q, state_d;
  grant_e              gnt_q;
  logic [ADR_W-1:0]    adr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdat_q;
  logic [SEL_W-1:0]    sel_q;
  logic [2:0]          cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                d_req, i_req, gnt_held, adr_ok, resp, enter_resp, rd_we;
  logic [1:0]          gnt;
  logic [ADR_W-1:0]    rd_adr;

  assign d_req    = d_cyc_in & d_stb_in;
  assign i_req    = i_cyc_in & i_stb_in;
  assign gnt_held = (gnt_q == GNT_I) ? i_req : d_req;
  assign adr_ok   = in_range(adr_q);
  assign resp     = (state_q == ST_RESP);

  wb_mem_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .d_req_i (d_req),
    .i_req_i (i_req),
    .take_i  (state_q == ST_IDLE),
    .gnt_o   (gnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|gnt) state_d = (WAIT > 0) ? ST_BUSY : ST_RESP;
      ST_BUSY: begin
        if (!gnt_held)            state_d = ST_IDLE;
        else if (cnt_q == 3'd1)   state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With WAIT=0 RESP is entered straight from IDLE, so the read address comes from the bus.
  always_comb begin
    rd_adr = adr_q;
    rd_we  = we_q;
    if (state_q == ST_IDLE) begin
      rd_adr = gnt[1] ? i_adr_in : d_adr_in;
      rd_we  = gnt[0] & d_we_in;
    end
  end

  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= GNT_D;
      adr_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && (|gnt)) begin
        gnt_q  <= gnt[1] ? GNT_I : GNT_D;
        adr_q  <= rd_adr;
        we_q   <= rd_we;
        wdat_q <= d_data_in;
        sel_q  <= gnt[1] ? '0 : d_sel_in;
        cnt_q  <= 3'(WAIT);
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (enter_resp) begin
        rdata_q <= (rd_we || !in_range(rd_adr)) ? '0 : mem[rd_adr[IDX_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resp && we_q && adr_ok) begin
      for (int unsigned b = 0; b < SEL_W; b++) begin
        if (sel_q[b]) mem[adr_q[IDX_W-1:0]][b*8 +: 8] <= wdat_q[b*8 +: 8];
      end
    end
  end

  assign d_akn_out   = resp && (gnt_q == GNT_D) && adr_ok;
  assign d_err_out   = resp && (gnt_q == GNT_D) && !adr_ok;
  assign i_akn_out   = resp && (gnt_q == GNT_I) && adr_ok;
  assign i_err_out   = resp && (gnt_q == GNT_I) && !adr_ok;
  assign d_data_out  = d_akn_out ? rdata_q : '0;
  assign i_instr_out = i_akn_out ? rdata_q : '0;

endmodule

// File: tb/tb_wb_dual_mem_slave.sv
// Self-checking bench for wb_dual_mem_slave (DATA_W=16, DEPTH=1024, WAIT=2).
module tb_wb_dual_mem_slave;

  localparam int DW = 16, AW = 16, DEP = 1024, WT = 2;

  logic          clk = 1'b0, rst = 1'b1;
  logic          d_cyc = 0, d_stb = 0, d_we = 0;
  logic [AW-1:0] d_adr = '0, i_adr = '0;
  logic [DW-1:0] d_dat = '0;
  logic [1:0]    d_sel = '0;
  logic          i_cyc = 0, i_stb = 0;
  logic [DW-1:0] d_data_out, i_instr_out;
  logic          d_akn_out, d_err_out, i_akn_out, i_err_out;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  wb_dual_mem_slave #(.DATA_W(DW), .ADR_W(AW), .DEPTH(DEP), .WAIT(WT)) dut (
    .clk(clk), .rst(rst),
    .d_cyc_in(d_cyc), .d_stb_in(d_stb), .d_we_in(d_we), .d_adr_in(d_adr),
    .d_data_in(d_dat), .d_sel_in(d_sel), .d_data_out(d_data_out),
    .d_akn_out(d_akn_out), .d_err_out(d_err_out),
    .i_cyc_in(i_cyc), .i_stb_in(i_stb), .i_adr_in(i_adr),
    .i_instr_out(i_instr_out), .i_akn_out(i_akn_out), .i_err_out(i_err_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a started access occupies edges k..k+WT+1, its
  // response is visible after edge k+WT, and the write lands at edge k+WT+1.
  int            n = 0, m_k = 0;
  bit            m_act = 0, m_port = 0, m_last = 1, m_we = 0;
  logic [15:0]   m_adr = '0, m_dat = '0;
  logic [1:0]    m_sel = '0;
  logic [15:0]   mm [int];

  task automatic model_step();
    bit rd, ri;
    logic [15:0] w;
    n++;
    if (rst) begin
      m_act = 0; m_last = 1;
      return;
    end
    rd = d_cyc && d_stb;
    ri = i_cyc && i_stb;
    if (m_act) begin
      if (n == m_k + WT + 1) begin
        if (m_we && int'(m_adr) < DEP) begin
          if (mm.exists(int'(m_adr))) begin
            w = mm[int'(m_adr)];
            if (m_sel[0]) w[7:0]  = m_dat[7:0];
            if (m_sel[1]) w[15:8] = m_dat[15:8];
            mm[int'(m_adr)] = w;
          end else if (m_sel == 2'b11) begin
            mm[int'(m_adr)] = m_dat;
          end
        end
        m_act = 0;
      end else if (!(m_port ? ri : rd)) begin
        m_act = 0;
      end
    end else if (rd || ri) begin
      m_port = (rd && ri) ? !m_last : ri;
      m_we   = m_port ? 1'b0 : d_we;
      m_adr  = m_port ? i_adr : d_adr;
      m_dat  = d_dat;
      m_sel  = d_sel;
      m_k    = n;
      m_last = m_port;
      m_act  = 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    bit resp, ok, known;
    logic [15:0] ed;
    @(negedge clk);
    resp  = m_act && (n == m_k + WT) && !rst;
    ok    = int'(m_adr) < DEP;
    known = mm.exists(int'(m_adr));
    ed    = known ? mm[int'(m_adr)] : 16'h0;
    chk("d_akn", d_akn_out, resp && !m_port && ok);
    chk("d_err", d_err_out, resp && !m_port && !ok);
    chk("i_akn", i_akn_out, resp && m_port && ok);
    chk("i_err", i_err_out, resp && m_port && !ok);
    if (!(resp && ok && !m_we && !known)) begin
      chk("d_data", d_data_out, (resp && !m_port && ok && !m_we) ? ed : 16'h0);
      chk("i_instr", i_instr_out, (resp && m_port && ok) ? ed : 16'h0);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic drop_all();
    d_cyc = 0; d_stb = 0; d_we = 0; i_cyc = 0; i_stb = 0;
  endtask

  task automatic do_reset();
    tick(); drop_all(); rst = 1;
    tick(); tick(); rst = 0;
  endtask

  // One access on a port; checks that the response appears 3 edges after the request.
  task automatic xfer(input bit port, input bit we, input logic [15:0] adr, input logic [15:0] dat,
                      input logic [1:0] sel, input string nm,
                      output logic [15:0] rdat, output bit akn, output bit err);
    int lat;
    lat = 0; akn = 0; err = 0; rdat = '0;
    tick();
    if (port) begin
      i_adr = adr; i_cyc = 1; i_stb = 1;
    end else begin
      d_we = we; d_adr = adr; d_dat = dat; d_sel = sel; d_cyc = 1; d_stb = 1;
    end
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (port ? (i_akn_out || i_err_out) : (d_akn_out || d_err_out)) begin
        lat  = c;
        akn  = port ? i_akn_out : d_akn_out;
        err  = port ? i_err_out : d_err_out;
        rdat = port ? i_instr_out : d_data_out;
      end
    end
    chk({nm, "_lat"}, lat, 3);
    tick();
    drop_all();
  endtask

  initial begin
    logic [15:0] r;
    bit a, e, dseen, iseen, ovl, got;
    int dl, il;
    bit d_on, i_on, dgot, igot;

    @(negedge clk);
    chk("rst_flags", {d_akn_out, d_err_out, i_akn_out, i_err_out}, 0);
    chk("rst_data", {d_data_out, i_instr_out}, 0);
    tick(); rst = 0;

    for (int ad = 0; ad < 64; ad++) xfer(0, 1, 16'(ad), 16'($urandom), 2'b11, "init", r, a, e);
    do_reset();

    // Simultaneous requests right after reset: data first, then instruction.
    tick();
    d_we = 0; d_adr = 16'h0010; d_cyc = 1; d_stb = 1;
    i_adr = 16'h0020; i_cyc = 1; i_stb = 1;
    dseen = 0; iseen = 0; ovl = 0; dl = 0; il = 0;
    for (int c = 1; c <= 20 && !iseen; c++) begin
      @(posedge clk); #2;
      if (dseen) begin d_cyc = 0; d_stb = 0; end
      @(negedge clk);
      if (d_akn_out && i_akn_out) ovl = 1;
      if (d_akn_out && !dseen) begin dseen = 1; dl = c; end
      if (i_akn_out && !iseen) begin iseen = 1; il = c; end
    end
    tick(); drop_all();
    chk("arb_d_lat", dl, 3);
    chk("arb_i_lat", il, 7);
    chk("arb_overlap", ovl, 0);

    xfer(0, 1, 16'h0010, 16'hBEEF, 2'b11, "wr_beef", r, a, e);
    chk("wr_beef_akn", a, 1);
    xfer(0, 0, 16'h0010, 16'h0, 2'b00, "rd_beef", r, a, e);
    chk("rd_beef", r, 16'hBEEF);
    xfer(0, 1, 16'h0010, 16'h12AB, 2'b01, "wr_lo", r, a, e);
    xfer(0, 0, 16'h0010, 16'h0, 2'b00, "rd_beab", r, a, e);
    chk("rd_beab", r, 16'hBEAB);
    xfer(0, 1, 16'h0010, 16'h7777, 2'b00, "wr_sel0", r, a, e);
    chk("wr_sel0_akn", a, 1);
    xfer(0, 0, 16'h0010, 16'h0, 2'b00, "rd_sel0", r, a, e);
    chk("rd_sel0", r, 16'hBEAB);

    xfer(1, 0, 16'h0400, 16'h0, 2'b00, "i_oor", r, a, e);
    chk("i_oor_err", e, 1);
    chk("i_oor_akn", a, 0);
    chk("i_oor_data", r, 0);
    @(negedge clk);
    chk("i_oor_pulse", i_err_out, 0);

    // Data write abandoned while waiting.
    xfer(0, 1, 16'h0011, 16'h1234, 2'b11, "pre_abort", r, a, e);
    tick();
    d_we = 1; d_adr = 16'h0011; d_dat = 16'h5555; d_sel = 2'b11; d_cyc = 1; d_stb = 1;
    tick();
    d_stb = 0;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d_akn_out || d_err_out) got = 1;
    end
    chk("abort_noresp", got, 0);
    drop_all();
    xfer(0, 0, 16'h0011, 16'h0, 2'b00, "rd_abort", r, a, e);
    chk("rd_abort", r, 16'h1234);

    // Reset in the middle of a write.
    xfer(0, 1, 16'h0005, 16'h0F0F, 2'b11, "pre_rst", r, a, e);
    tick();
    d_we = 1; d_adr = 16'h0005; d_dat = 16'hAAAA; d_sel = 2'b11; d_cyc = 1; d_stb = 1;
    tick();
    rst = 1; drop_all();
    #1;
    chk("rst_busy_flags", {d_akn_out, d_err_out, i_akn_out, i_err_out}, 0);
    tick(); tick(); rst = 0;
    xfer(0, 0, 16'h0005, 16'h0, 2'b00, "rd_rst", r, a, e);
    chk("rd_rst", r, 16'h0F0F);

    // Randomized traffic on both ports against the reference model.
    d_on = 0; i_on = 0; dgot = 0; igot = 0;
    for (int it = 0; it < 4000; it++) begin
      int sel_a;
      @(posedge clk); #2;
      if (rst) rst = 0;
      else if ($urandom_range(0, 599) == 0) rst = 1;
      if (d_on && (dgot || $urandom_range(0, 39) == 0)) begin
        d_cyc = 0; d_stb = 0; d_on = 0;
      end else if (!d_on && $urandom_range(0, 2) == 0) begin
        sel_a = $urandom_range(0, 15);
        d_adr = (sel_a == 0) ? 16'(16'h0400 + $urandom_range(0, 3)) :
                (sel_a == 1) ? 16'hFFFF : 16'($urandom_range(0, 63));
        d_we  = $urandom_range(0, 1) == 1;
        d_dat = 16'($urandom);
        d_sel = 2'($urandom_range(0, 3));
        d_cyc = 1; d_stb = ($urandom_range(0, 7) != 0); d_on = 1;
      end
      if (i_on && (igot || $urandom_range(0, 39) == 0)) begin
        i_cyc = 0; i_stb = 0; i_on = 0;
      end else if (!i_on && $urandom_range(0, 2) == 0) begin
        sel_a = $urandom_range(0, 15);
        i_adr = (sel_a == 0) ? 16'(16'h0400 + $urandom_range(0, 3)) : 16'($urandom_range(0, 63));
        i_cyc = 1; i_stb = ($urandom_range(0, 7) != 0); i_on = 1;
      end
      @(negedge clk);
      dgot = d_akn_out || d_err_out;
      igot = i_akn_out || i_err_out;
    end
    tick(); drop_all(); rst = 0;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
